sub_bytes_seq: RTL and testbench

Sequential AES SubBytes stage that feeds the ShiftRows stage of the lab 7 AES core. It captures a 128-bit state on a start pulse and substitutes all 16 bytes through a synchronous (registered-output) S-box. The synchronous S-box maps onto iCE40 block RAM instead of LUTs. The block is time-multiplexed: LANES bytes are substituted per cycle, and the block signals completion with a one-cycle done pulse. The result is presented as a stable 128-bit word for the downstream combinational ShiftRows.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/sbox_sync.sv | 14 +
 rtl/sub_bytes_seq.sv | 97 +++++++++
 tb/tb_sub_bytes_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: SubBytes FSM states, block size and the FIPS-197 forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int AES_BYTES = 16;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sbox_sync.sv
// Forward AES S-box with a registered output; no reset so the table maps onto block RAM.
module sbox_sync
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] a,
  output logic [7:0] y
);

  always_ff @(posedge clk) begin
    y <= SBOX[a];
  end

endmodule

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed AES SubBytes: LANES bytes per cycle through synchronous S-boxes,
// full 128-bit result published together with a one-cycle done pulse.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] a,
  output logic         busy,
  output logic         done,
  output logic [127:0] y,
  output state_t       dbg_state
);

  localparam int N  = AES_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = 8 * LANES;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   wr_idx;
  logic [127:0]    in_reg;
  logic [127:0]    sh;
  logic [127:0]    merged;
  logic [GW-1:0]   rd_group;
  logic [GW-1:0]   sb_out;
  int              rd_base;
  int              wr_base;

  assign dbg_state = state;

  // Byte 0 sits at the MSB, so group g occupies bits [127-GW*g -: GW].
  always_comb begin
    rd_base  = 127 - GW * int'(cnt);
    wr_base  = 127 - GW * int'(wr_idx);
    rd_group = in_reg[rd_base -: GW];
    merged   = sh;
    merged[wr_base -: GW] = sb_out;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_sync u_sbox (
      .clk (clk),
      .a   (rd_group[GW-1-8*l -: 8]),
      .y   (sb_out[GW-1-8*l -: 8])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_idx <= '0;
      in_reg <= '0;
      sh     <= '0;
      y      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_reg <= a;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          wr_idx <= cnt;
          // S-box data is one cycle behind its address; nothing valid on the first RUN edge.
          if (cnt != '0) begin
            sh[wr_base -: GW] <= sb_out;
          end
          if (cnt == CW'(N - 1)) begin
            state <= FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          sh[wr_base -: GW] <= sb_out;
          y     <= merged;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq with LANES = 1, 2 and 4 instances sharing clock and reset.
module tb_sub_bytes_seq;
  import aes_pkg::*;

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] BO_IN    = {4{32'h000153ff}};
  localparam logic [127:0] BO_OUT   = {4{32'h637ced16}};
  localparam logic [127:0] B0_IN    = {8'h53, 120'h0};
  localparam logic [127:0] B0_OUT   = {8'hed, {15{8'h63}}};

  logic         clk = 1'b0;
  logic         reset;
  logic         start1, start2, start4;
  logic [127:0] a1, a2, a4;
  logic         busy1, busy2, busy4;
  logic         done1, done2, done4;
  logic [127:0] y1, y2, y4;
  state_t       st1, st2, st4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sub_bytes_seq #(.LANES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1),
    .busy(busy1), .done(done1), .y(y1), .dbg_state(st1)
  );
  sub_bytes_seq #(.LANES(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2),
    .busy(busy2), .done(done2), .y(y2), .dbg_state(st2)
  );
  sub_bytes_seq #(.LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4),
    .busy(busy4), .done(done4), .y(y4), .dbg_state(st4)
  );

  // Driver: one start pulse, then observe each negedge. lat counts edges after the accept edge.
  task automatic run_block(input int lanes, input logic [127:0] din, output logic [127:0] y_got,
                           output int lat, output int busy_cnt, output int ndone);
    logic         b, d;
    logic [127:0] yy;
    int           nn;
    nn = 16 / lanes;
    @(negedge clk);
    case (lanes)
      1:       begin start1 = 1'b1; a1 = din; end
      2:       begin start2 = 1'b1; a2 = din; end
      default: begin start4 = 1'b1; a4 = din; end
    endcase
    @(posedge clk);
    #1;
    start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    a1 = {4{$urandom}}; a2 = {4{$urandom}}; a4 = {4{$urandom}};
    lat = -1; ndone = 0; busy_cnt = 0; y_got = '0;
    for (int n = 0; n < nn + 10; n++) begin
      @(negedge clk);
      case (lanes)
        1:       begin b = busy1; d = done1; yy = y1; end
        2:       begin b = busy2; d = done2; yy = y2; end
        default: begin b = busy4; d = done4; yy = y4; end
      endcase
      if (b) busy_cnt++;
      if (d) begin
        ndone++;
        if (lat < 0) begin
          lat   = n;
          y_got = yy;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    a1 = '0; a2 = '0; a4 = '0;
    #12;
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b want 0", done1); end
    n_cmp++; if (y1 !== 128'h0) begin n_fail++; $display("FAIL reset_y1: got %h want 0", y1); end
    n_cmp++; if (st1 !== IDLE) begin n_fail++; $display("FAIL reset_state1: got %0d want IDLE", st1); end
    n_cmp++; if (st2 !== IDLE || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2: state %0d busy %b", st2, busy2); end
    n_cmp++; if (y4 !== 128'h0 || done4 !== 1'b0) begin n_fail++; $display("FAIL reset_dut4: y %h done %b", y4, done4); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_zero();
    logic [127:0] yg;
    int lat, bc, nd;
    run_block(1, 128'h0, yg, lat, bc, nd);
    n_cmp++; if (yg !== ZERO_OUT) begin n_fail++; $display("FAIL zero_y: got %h want %h", yg, ZERO_OUT); end
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL zero_latency: got %0d want 17", lat); end
    n_cmp++; if (bc !== 17) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 17", bc); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_app_b();
    logic [127:0] yg;
    int lat, bc, nd;
    int lanes_tab [3] = '{1, 2, 4};
    int lat_tab   [3] = '{17, 9, 5};
    for (int i = 0; i < 3; i++) begin
      run_block(lanes_tab[i], APPB_IN, yg, lat, bc, nd);
      n_cmp++; if (yg !== APPB_OUT) begin n_fail++; $display("FAIL appb_y_l%0d: got %h want %h", lanes_tab[i], yg, APPB_OUT); end
      n_cmp++; if (lat !== lat_tab[i]) begin n_fail++; $display("FAIL appb_latency_l%0d: got %0d want %0d", lanes_tab[i], lat, lat_tab[i]); end
      n_cmp++; if (bc !== lat_tab[i]) begin n_fail++; $display("FAIL appb_busy_l%0d: got %0d want %0d", lanes_tab[i], bc, lat_tab[i]); end
      n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL appb_done_count_l%0d: got %0d want 1", lanes_tab[i], nd); end
    end
  endtask

  task automatic test_byte_order();
    logic [127:0] yg;
    int lat, bc, nd;
    run_block(1, BO_IN, yg, lat, bc, nd);
    n_cmp++; if (yg !== BO_OUT) begin n_fail++; $display("FAIL byte_order_y: got %h want %h", yg, BO_OUT); end
    run_block(2, B0_IN, yg, lat, bc, nd);
    n_cmp++; if (yg[127:120] !== 8'hed) begin n_fail++; $display("FAIL byte0_msb: got %h want ed", yg[127:120]); end
    n_cmp++; if (yg !== B0_OUT) begin n_fail++; $display("FAIL byte0_full: got %h want %h", yg, B0_OUT); end
  endtask

  task automatic test_ignore_start();
    logic [127:0] yg;
    int lat, nd;
    @(negedge clk);
    start1 = 1'b1; a1 = APPB_IN;
    @(posedge clk);
    #1;
    start1 = 1'b0; a1 = '0;
    lat = -1; nd = 0; yg = '0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 4) begin start1 = 1'b1; a1 = BO_IN; end
      if (n == 5) start1 = 1'b0;
      if (done1) begin
        nd++;
        if (lat < 0) begin lat = n; yg = y1; end
      end
    end
    n_cmp++; if (yg !== APPB_OUT) begin n_fail++; $display("FAIL ignore_start_y: got %h want %h", yg, APPB_OUT); end
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL ignore_start_latency: got %0d want 17", lat); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_start_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vec [3] = '{APPB_IN, 128'h0, BO_IN};
    logic [127:0] exp_v [3] = '{APPB_OUT, ZERO_OUT, BO_OUT};
    int pos [3] = '{-1, -1, -1};
    logic [127:0] last_y;
    int blk;
    bit stable_ok;
    @(negedge clk);
    start1 = 1'b1; a1 = vec[0];
    last_y = y1; blk = 0; stable_ok = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (done1) begin
        if (blk < 3) begin
          pos[blk] = n;
          n_cmp++; if (y1 !== exp_v[blk]) begin n_fail++; $display("FAIL b2b_y%0d: got %h want %h", blk, y1, exp_v[blk]); end
        end
        blk++;
        last_y = y1;
        // The edge that ends the done cycle accepts the next block.
        if (blk < 3) a1 = vec[blk];
        else start1 = 1'b0;
      end else if (y1 !== last_y) begin
        stable_ok = 1'b0;
      end
    end
    start1 = 1'b0;
    n_cmp++; if (blk !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", blk); end
    n_cmp++; if (pos[0] !== 17) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 17", pos[0]); end
    n_cmp++; if (pos[1] - pos[0] !== 18) begin n_fail++; $display("FAIL b2b_spacing1: got %0d want 18", pos[1] - pos[0]); end
    n_cmp++; if (pos[2] - pos[1] !== 18) begin n_fail++; $display("FAIL b2b_spacing2: got %0d want 18", pos[2] - pos[1]); end
    n_cmp++; if (stable_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_y_stable: got %b want 1", stable_ok); end
  endtask

  task automatic test_async_reset();
    logic [127:0] yg;
    int lat, bc, nd;
    int late_done;
    @(negedge clk);
    start1 = 1'b1; a1 = APPB_IN;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int n = 0; n < 8; n++) @(negedge clk);
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL areset_pre_busy: got %b want 1", busy1); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy1); end
    n_cmp++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %b want 0", done1); end
    n_cmp++; if (y1 !== 128'h0) begin n_fail++; $display("FAIL areset_y: got %h want 0", y1); end
    n_cmp++; if (st1 !== IDLE) begin n_fail++; $display("FAIL areset_state: got %0d want IDLE", st1); end
    @(negedge clk);
    reset = 1'b0;
    late_done = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done1 || busy1) late_done++;
    end
    n_cmp++; if (late_done !== 0) begin n_fail++; $display("FAIL areset_no_done: got %0d active cycles want 0", late_done); end
    run_block(1, APPB_IN, yg, lat, bc, nd);
    n_cmp++; if (yg !== APPB_OUT) begin n_fail++; $display("FAIL areset_rerun_y: got %h want %h", yg, APPB_OUT); end
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL areset_rerun_latency: got %0d want 17", lat); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_app_b();
    test_byte_order();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
